// File: rtl/cache_pkg.sv
// Shared cache definitions: fill FSM state encoding and default block geometry,
// used by cache_fill_fsm and cache_controller.
package cache_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam int CACHE_BLOCK_WORDS = 8;
    localparam int CACHE_WORD_OFF_W  = $clog2(CACHE_BLOCK_WORDS);

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and enable. It saturates at MAX and flags
// when the count equals TC_VALUE.
module fill_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 8,
    parameter int TC_VALUE = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] CNT_TC  = WIDTH'(TC_VALUE);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == CNT_TC);

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill sequencer: issues BLOCK_WORDS back-to-back memory reads and writes
// the returned words into the data array. Define CACHE_FILL_MISS_CNT_EN to add miss_count.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = CACHE_BLOCK_WORDS,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic [15:0]                    memory_data,
    input  logic                           memory_data_valid,
    output logic                           memory_read_en,
    output logic [ADDR_W-1:0]              memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_offset,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array,
`ifdef CACHE_FILL_MISS_CNT_EN
    output logic [15:0]                    miss_count,
    output logic                           fsm_busy
`else
    output logic                           fsm_busy
`endif
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = OFF_W + 1;
    localparam int BLK_W = ADDR_W - OFF_W - 1;

    fill_state_e      state_reg;
    fill_state_e      state_next;
    logic [BLK_W-1:0] blk_addr_reg;

    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] recv_cnt;
    logic             issue_done;
    logic             recv_last;

    logic in_fill;
    logic accept_miss;
    logic issuing;
    logic receiving;
    logic last_word;

    assign in_fill     = (state_reg == FILL);
    assign accept_miss = (state_reg == IDLE) && miss_detected;
    assign issuing     = in_fill && !issue_done;
    assign receiving   = in_fill && memory_data_valid;
    assign last_word   = receiving && recv_last;

    fill_counter #(
        .WIDTH   (CNT_W),
        .MAX     (BLOCK_WORDS),
        .TC_VALUE(BLOCK_WORDS)
    ) u_issue_cnt (
        .clk  (clk),
        .srst (rst),
        .clr  (accept_miss),
        .en   (issuing),
        .count(issue_cnt),
        .tc   (issue_done)
    );

    // The receive flag fires on the last word so the tag write lands with it.
    fill_counter #(
        .WIDTH   (CNT_W),
        .MAX     (BLOCK_WORDS),
        .TC_VALUE(BLOCK_WORDS - 1)
    ) u_recv_cnt (
        .clk  (clk),
        .srst (rst),
        .clr  (accept_miss),
        .en   (receiving),
        .count(recv_cnt),
        .tc   (recv_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (miss_detected) state_next = FILL;
            FILL:    if (last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            blk_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept_miss) begin
                blk_addr_reg <= miss_address[ADDR_W-1:OFF_W+1];
            end
        end
    end

    assign fsm_busy         = in_fill;
    assign memory_read_en   = issuing;
    assign memory_address   = issuing ? {blk_addr_reg, issue_cnt[OFF_W-1:0], 1'b0} : '0;
    assign write_data_array = receiving;
    assign fill_word_offset = receiving ? recv_cnt[OFF_W-1:0] : '0;
    assign fill_data        = memory_data;
    assign write_tag_array  = last_word;

    // Count MSBs only mark completion; the low address bits select within a block.
    logic unused_bits;
    assign unused_bits = ^{issue_cnt[OFF_W], recv_cnt[OFF_W], miss_address[OFF_W:0]};

`ifdef CACHE_FILL_MISS_CNT_EN
    logic [15:0] miss_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count_reg <= '0;
        end else if (accept_miss && (miss_count_reg != 16'hFFFF)) begin
            miss_count_reg <= miss_count_reg + 16'd1;
        end
    end

    assign miss_count = miss_count_reg;
`endif

endmodule
